host_mst_arb: RTL and testbench
===============================

# host_mst_arb

Credit-limited, weighted round-robin issue controller for the two host-master requesters (index 0 = DMA, index 1 = host-direct). It sits in front of the host master mux and gates each requester's AW/AR valid/ready. The mux's downstream ID remapper has finite table capacity, so the block bounds outstanding transactions per port and in total, and it enforces a DMA:host-direct grant ratio.

## Interface
- MaxTxnTotal, 8: max outstanding transactions per direction (write or read) summed over both ports.
- MaxTxnPerPort, 6: max outstanding transactions per direction per port.
- DmaWeight, 3: consecutive DMA grants allowed before host-direct is forced, when both are eligible.
- CntWidth, $clog2(MaxTxnTotal+1): counter width; derived, do not override.
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- enable_i  in  1  0 = no new grants; in-flight handshakes complete.
- slv_aw_valid_i / slv_aw_ready_o  in/out  2  AW handshake with requesters.
- mst_aw_valid_o / mst_aw_ready_i  out/in  2  AW handshake toward mux inputs.
- slv_ar_valid_i / slv_ar_ready_o, mst_ar_valid_o / mst_ar_ready_i  2 each  AR equivalents.
- b_done_i  in  2  one pulse per completed B handshake on port p.
- r_done_i  in  2  one pulse per completed R-last handshake on port p.
- wr_out_o / rd_out_o  out  2*CntWidth  outstanding counters per port, port p at bits [p*CntWidth +: CntWidth].
- idle_o  out  1  all outstanding counters zero and both channel FSMs in IDLE.
- err_underflow_o  out  1  sticky: a done pulse arrived while that counter was 0.

## Operation
- Each channel (AW, AR) has an independent FSM with states IDLE, GNT_DMA, GNT_HDIR. Everything below applies per channel. Writes use wr counters and b_done_i; reads use rd counters and r_done_i.
- Port p is eligible when all hold: slv_valid_i[p], enable_i, out[p] < MaxTxnPerPort, and out[0]+out[1] < MaxTxnTotal.
- In IDLE, selection rules:
  - Both eligible: DMA wins if streak < DmaWeight, else host-direct wins.
  - One eligible: it wins.
  - Next state is GNT_p.
  - A grant to DMA increments streak, saturating at DmaWeight. A grant to host-direct clears streak.
- In GNT_p:
  - mst_valid_o[p] = slv_valid_i[p]; slv_ready_o[p] = mst_ready_i[p]; the other port sees valid/ready 0.
  - On handshake (mst_valid_o & mst_ready_i): out[p] increments and the FSM returns to IDLE.
  - The grant is held regardless of enable_i or credits, so an asserted valid never drops before its handshake.
- Counters:
  - Issue and done on the same port and direction in the same cycle: net 0.
  - Done while counter is 0: counter holds 0 and err_underflow_o sets, cleared only by reset.
  - The issue path can never exceed the limits.
- In IDLE, all mst_valid_o and slv_ready_o are 0.

## Timing
- Reset (async assert): FSMs to IDLE, streaks 0, all counters 0, err_underflow_o 0, idle_o 1. All valid/ready outputs drop to 0 immediately.
- Grant latency: valid sampled in IDLE at cycle N gives mst_valid_o at N+1. The handshake can complete in N+1. Next selection happens in IDLE at N+2, so peak issue is 1 transaction per 2 cycles per channel.
- Counters update on the clock edge after the handshake or done pulse. Credits freed at edge N are usable by selection in cycle N+1.
- mst_valid_o and slv_ready_o are combinational from registered state plus the pass-through input; there is no combinational path from done inputs to them.
- Reset asserted mid-transaction abandons the grant; in-flight counts are lost by design.

## Configuration
- HOST_MST_ARB_STATS_EN defined: adds output stall_cnt_o (2*32). Entry p counts cycles where port p has slv_aw_valid_i or slv_ar_valid_i high and no mst handshake on either channel of that port. Counts saturate at 2^32-1 and reset to 0.
- Undefined: port and counters absent; behaviour otherwise identical.

## Test plan
- Single DMA AW with mst_aw_ready_i=1: valid at cycle 0 -> mst_aw_valid_o[0] at cycle 1, wr_out port0 = 1 at cycle 2; b_done_i[0] pulse -> counter 0, idle_o=1.
- Both ports hold AR valid continuously, ready=1, DmaWeight=3, immediate r_done: grant order D,D,D,H,D,D,D,H.
- DMA issues 6 writes without B -> 7th write stays blocked (slv_aw_ready_o[0]=0). Host-direct issues 2 -> total 8, its 3rd blocks. One b_done_i[1] -> host-direct proceeds.
- mst_aw_ready_i=0 for 5 cycles during GNT_DMA and enable_i drops -> mst_aw_valid_o[0] stays 1 until handshake, then no new grants.
- b_done_i[1] pulse with wr_out port1 = 0 -> counter stays 0, err_underflow_o=1 until rst_i.
- rst_i asserted while in GNT_HDIR with 3 reads outstanding -> same cycle all valids 0; after release counters 0 and idle_o=1.

Source files
------------

// File: rtl/host_mst_arb_if.sv
// AW/AR valid/ready handshake bundle between the two host requesters, host_mst_arb and the master mux.
// Signal suffixes are from the arbiter's point of view; "slave" is the arbiter side, "master" the environment side.
interface host_mst_arb_if;
   logic [1:0] slv_aw_valid_i;
   logic [1:0] slv_aw_ready_o;
   logic [1:0] mst_aw_valid_o;
   logic [1:0] mst_aw_ready_i;
   logic [1:0] slv_ar_valid_i;
   logic [1:0] slv_ar_ready_o;
   logic [1:0] mst_ar_valid_o;
   logic [1:0] mst_ar_ready_i;

   modport slave (
      input  slv_aw_valid_i, mst_aw_ready_i, slv_ar_valid_i, mst_ar_ready_i,
      output slv_aw_ready_o, mst_aw_valid_o, slv_ar_ready_o, mst_ar_valid_o
   );

   modport master (
      output slv_aw_valid_i, mst_aw_ready_i, slv_ar_valid_i, mst_ar_ready_i,
      input  slv_aw_ready_o, mst_aw_valid_o, slv_ar_ready_o, mst_ar_valid_o
   );
endinterface

// File: rtl/host_mst_arb.sv
// Credit-limited weighted round-robin AW/AR issue gate for DMA (port 0) and host-direct (port 1); grant one cycle after
// valid, held until handshake, 1 txn per 2 cycles per channel. Optional HOST_MST_ARB_STATS_EN adds per-port stall counters.
module host_mst_arb_chan #(
   parameter int MaxTxnTotal   = 8,
   parameter int MaxTxnPerPort = 6,
   parameter int DmaWeight     = 3,
   parameter int CntWidth      = $clog2(MaxTxnTotal + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  enable_i,
   input  logic [1:0]            slv_valid_i,
   output logic [1:0]            slv_ready_o,
   output logic [1:0]            mst_valid_o,
   input  logic [1:0]            mst_ready_i,
   input  logic [1:0]            done_i,
   output logic [2*CntWidth-1:0] out_o,
   output logic                  idle_o,
   output logic                  err_o
);
   localparam int SW = $clog2(DmaWeight + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, GNT_DMA = 2'd1, GNT_HDIR = 2'd2} state_e;

   state_e                state_q, state_d;
   logic [SW-1:0]         streak_q, streak_d;
   logic [CntWidth-1:0]   cnt_q [2];
   logic [CntWidth-1:0]   cnt_d [2];
   logic [1:0]            err_set;
   logic                  err_q;
   logic [CntWidth:0]     total;
   logic                  total_ok;
   logic [1:0]            elig;
   logic [1:0]            gnt;
   logic [1:0]            hs;

   assign gnt         = {state_q == GNT_HDIR, state_q == GNT_DMA};
   assign mst_valid_o = gnt & slv_valid_i;
   assign slv_ready_o = gnt & mst_ready_i;
   assign hs          = mst_valid_o & mst_ready_i;

   assign total    = {1'b0, cnt_q[0]} + {1'b0, cnt_q[1]};
   assign total_ok = total < (CntWidth + 1)'(MaxTxnTotal);

   always_comb begin
      state_d  = state_q;
      streak_d = streak_q;
      case (state_q)
         IDLE: begin
            // DMA wins unless host-direct also wants in and DMA has used its streak
            if (elig[0] && (!elig[1] || streak_q < SW'(DmaWeight))) begin
               state_d = GNT_DMA;
               if (streak_q < SW'(DmaWeight)) streak_d = streak_q + 1'b1;
            end else if (elig[1]) begin
               state_d  = GNT_HDIR;
               streak_d = '0;
            end
         end
         GNT_DMA:  if (hs[0]) state_d = IDLE;
         GNT_HDIR: if (hs[1]) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         streak_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         streak_q <= streak_d;
         err_q    <= err_q | (|err_set);
      end
   end

   for (genvar p = 0; p < 2; p++) begin : g_port
      assign elig[p] = slv_valid_i[p] & enable_i & total_ok &
                       (cnt_q[p] < CntWidth'(MaxTxnPerPort));

      always_comb begin
         cnt_d[p]   = cnt_q[p];
         err_set[p] = 1'b0;
         if (hs[p] && !done_i[p]) begin
            cnt_d[p] = cnt_q[p] + 1'b1;
         end else if (!hs[p] && done_i[p]) begin
            if (cnt_q[p] == '0) err_set[p] = 1'b1;
            else                cnt_d[p]   = cnt_q[p] - 1'b1;
         end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) cnt_q[p] <= '0;
         else       cnt_q[p] <= cnt_d[p];
      end
   end

   assign out_o  = {cnt_q[1], cnt_q[0]};
   assign idle_o = (state_q == IDLE) && (cnt_q[0] == '0) && (cnt_q[1] == '0);
   assign err_o  = err_q;
endmodule

module host_mst_arb #(
   parameter int MaxTxnTotal   = 8,
   parameter int MaxTxnPerPort = 6,
   parameter int DmaWeight     = 3,
   parameter int CntWidth      = $clog2(MaxTxnTotal + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  enable_i,
   host_mst_arb_if.slave         bus,
   input  logic [1:0]            b_done_i,
   input  logic [1:0]            r_done_i,
   output logic [2*CntWidth-1:0] wr_out_o,
   output logic [2*CntWidth-1:0] rd_out_o,
   output logic                  idle_o,
`ifdef HOST_MST_ARB_STATS_EN
   output logic [2*32-1:0]       stall_cnt_o,
`endif
   output logic                  err_underflow_o
);
   logic aw_idle, ar_idle, aw_err, ar_err;

   host_mst_arb_chan #(
      .MaxTxnTotal(MaxTxnTotal), .MaxTxnPerPort(MaxTxnPerPort),
      .DmaWeight(DmaWeight), .CntWidth(CntWidth)
   ) u_aw (
      .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i),
      .slv_valid_i(bus.slv_aw_valid_i), .slv_ready_o(bus.slv_aw_ready_o),
      .mst_valid_o(bus.mst_aw_valid_o), .mst_ready_i(bus.mst_aw_ready_i),
      .done_i(b_done_i), .out_o(wr_out_o), .idle_o(aw_idle), .err_o(aw_err)
   );

   host_mst_arb_chan #(
      .MaxTxnTotal(MaxTxnTotal), .MaxTxnPerPort(MaxTxnPerPort),
      .DmaWeight(DmaWeight), .CntWidth(CntWidth)
   ) u_ar (
      .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i),
      .slv_valid_i(bus.slv_ar_valid_i), .slv_ready_o(bus.slv_ar_ready_o),
      .mst_valid_o(bus.mst_ar_valid_o), .mst_ready_i(bus.mst_ar_ready_i),
      .done_i(r_done_i), .out_o(rd_out_o), .idle_o(ar_idle), .err_o(ar_err)
   );

   assign idle_o          = aw_idle & ar_idle;
   assign err_underflow_o = aw_err | ar_err;

`ifdef HOST_MST_ARB_STATS_EN
   logic [31:0] stall_q [2];
   logic [1:0]  stalled;

   assign stalled = (bus.slv_aw_valid_i | bus.slv_ar_valid_i) &
                    ~((bus.mst_aw_valid_o & bus.mst_aw_ready_i) |
                      (bus.mst_ar_valid_o & bus.mst_ar_ready_i));

   for (genvar p = 0; p < 2; p++) begin : g_stall
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i)                             stall_q[p] <= '0;
         else if (stalled[p] && ~&stall_q[p])   stall_q[p] <= stall_q[p] + 1'b1;
      end
   end

   assign stall_cnt_o = {stall_q[1], stall_q[0]};
`endif
endmodule

// File: tb/tb_host_mst_arb.sv
// Directed plus randomized bench for host_mst_arb checked against a transaction-level model of the issue rules.
module tb_host_mst_arb;
   localparam int MT = 8;
   localparam int MP = 6;
   localparam int DW = 3;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic [1:0]    b_done = 2'b00;
   logic [1:0]    r_done = 2'b00;
   logic [2*CW-1:0] wr_out, rd_out;
   logic          idle, err;
`ifdef HOST_MST_ARB_STATS_EN
   logic [63:0]   stall_cnt;
`endif

   host_mst_arb_if bus();

   host_mst_arb dut (
      .clk_i(clk), .rst_i(rst), .enable_i(enable), .bus(bus),
      .b_done_i(b_done), .r_done_i(r_done),
      .wr_out_o(wr_out), .rd_out_o(rd_out), .idle_o(idle),
`ifdef HOST_MST_ARB_STATS_EN
      .stall_cnt_o(stall_cnt),
`endif
      .err_underflow_o(err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model: channel c (0 = write, 1 = read), port p; m_gnt = port holding the grant or -1
   int m_cnt [2][2];
   int m_gnt [2];
   int m_streak [2];
   bit m_err;
   bit m_hs [2][2];
   int ar_log [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit vld(input int c, input int p);
      return (c == 0) ? bus.slv_aw_valid_i[p[0]] : bus.slv_ar_valid_i[p[0]];
   endfunction

   function automatic bit rdy(input int c, input int p);
      return (c == 0) ? bus.mst_aw_ready_i[p[0]] : bus.mst_ar_ready_i[p[0]];
   endfunction

   function automatic bit dn(input int c, input int p);
      return (c == 0) ? b_done[p[0]] : r_done[p[0]];
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         m_gnt[c] = -1;
         m_streak[c] = 0;
         for (int p = 0; p < 2; p++) begin
            m_cnt[c][p] = 0;
            m_hs[c][p] = 1'b0;
         end
      end
      m_err = 1'b0;
   endtask

   task automatic model_update();
      bit e [2];
      int win;
      for (int c = 0; c < 2; c++) begin
         for (int p = 0; p < 2; p++)
            m_hs[c][p] = (m_gnt[c] == p) && vld(c, p) && rdy(c, p);
         if (m_gnt[c] < 0) begin
            for (int p = 0; p < 2; p++)
               e[p] = vld(c, p) && enable && (m_cnt[c][p] < MP) &&
                      (m_cnt[c][0] + m_cnt[c][1] < MT);
            if (e[0] && e[1]) win = (m_streak[c] < DW) ? 0 : 1;
            else if (e[0])    win = 0;
            else if (e[1])    win = 1;
            else              win = -1;
            if (win == 0) m_streak[c] = (m_streak[c] + 1 > DW) ? DW : m_streak[c] + 1;
            if (win == 1) m_streak[c] = 0;
            m_gnt[c] = win;
         end else if (m_hs[c][m_gnt[c]]) begin
            m_gnt[c] = -1;
         end
         for (int p = 0; p < 2; p++) begin
            if (m_hs[c][p] && !dn(c, p)) m_cnt[c][p]++;
            else if (!m_hs[c][p] && dn(c, p)) begin
               if (m_cnt[c][p] == 0) m_err = 1'b1;
               else                  m_cnt[c][p]--;
            end
         end
      end
   endtask

   task automatic check_outputs();
      logic [1:0] ev [2];
      logic [1:0] er [2];
      logic [7:0] ew, erd;
      bit         eidle;
      for (int c = 0; c < 2; c++) begin
         ev[c] = 2'b00;
         er[c] = 2'b00;
         if (m_gnt[c] >= 0) begin
            ev[c][m_gnt[c][0]] = vld(c, m_gnt[c]);
            er[c][m_gnt[c][0]] = rdy(c, m_gnt[c]);
         end
      end
      ew    = {4'(m_cnt[0][1]), 4'(m_cnt[0][0])};
      erd   = {4'(m_cnt[1][1]), 4'(m_cnt[1][0])};
      eidle = (m_gnt[0] < 0) && (m_gnt[1] < 0) &&
              (m_cnt[0][0] + m_cnt[0][1] + m_cnt[1][0] + m_cnt[1][1] == 0);
      chk("aw_valid", 64'(bus.mst_aw_valid_o), 64'(ev[0]));
      chk("aw_ready", 64'(bus.slv_aw_ready_o), 64'(er[0]));
      chk("ar_valid", 64'(bus.mst_ar_valid_o), 64'(ev[1]));
      chk("ar_ready", 64'(bus.slv_ar_ready_o), 64'(er[1]));
      chk("wr_out", 64'(wr_out), 64'(ew));
      chk("rd_out", 64'(rd_out), 64'(erd));
      chk("idle", 64'(idle), 64'(eidle));
      chk("err", 64'(err), 64'(m_err));
   endtask

   task automatic step();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic all_inputs_zero();
      bus.slv_aw_valid_i = 2'b00; bus.mst_aw_ready_i = 2'b00;
      bus.slv_ar_valid_i = 2'b00; bus.mst_ar_ready_i = 2'b00;
      b_done = 2'b00; r_done = 2'b00;
   endtask

   task automatic drain();
      repeat (40) begin
         for (int p = 0; p < 2; p++) begin
            bus.slv_aw_valid_i[p] = (m_gnt[0] == p);
            bus.slv_ar_valid_i[p] = (m_gnt[1] == p);
            b_done[p] = (m_cnt[0][p] > 0);
            r_done[p] = (m_cnt[1][p] > 0);
         end
         bus.mst_aw_ready_i = 2'b11;
         bus.mst_ar_ready_i = 2'b11;
         enable = 1'b0;
         step();
      end
      all_inputs_zero();
      enable = 1'b1;
   endtask

   initial begin
      int exp_order [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
      model_reset();
      all_inputs_zero();

      // reset state
      #12;
      chk("rst_idle", 64'(idle), 64'(1));
      chk("rst_wr_out", 64'(wr_out), 64'(0));
      chk("rst_err", 64'(err), 64'(0));
      chk("rst_aw_valid", 64'(bus.mst_aw_valid_o), 64'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      // single DMA write
      enable = 1'b1;
      bus.slv_aw_valid_i = 2'b01;
      bus.mst_aw_ready_i = 2'b11;
      step();
      chk("t1_grant_lat", 64'(bus.mst_aw_valid_o), 64'(2'b01));
      step();
      bus.slv_aw_valid_i = 2'b00;
      chk("t1_wr_out", 64'(wr_out), 64'(8'h01));
      b_done = 2'b01;
      step();
      b_done = 2'b00;
      chk("t1_wr_drained", 64'(wr_out), 64'(0));
      chk("t1_idle", 64'(idle), 64'(1));

      // weighted round robin on AR
      bus.slv_ar_valid_i = 2'b11;
      bus.mst_ar_ready_i = 2'b11;
      ar_log.delete();
      repeat (16) begin
         r_done = {m_hs[1][1], m_hs[1][0]};
         step();
         if (bus.mst_ar_valid_o != 2'b00) ar_log.push_back(bus.mst_ar_valid_o[1] ? 1 : 0);
      end
      bus.slv_ar_valid_i = 2'b00;
      chk("t2_ngrants", 64'(ar_log.size() >= 8), 64'(1));
      for (int i = 0; i < 8 && i < ar_log.size(); i++)
         chk($sformatf("t2_order%0d", i), 64'(ar_log[i]), 64'(exp_order[i]));
      drain();

      // credit limits
      bus.slv_aw_valid_i = 2'b01;
      bus.mst_aw_ready_i = 2'b11;
      repeat (12) step();
      chk("t3_dma6", 64'(wr_out), 64'(8'h06));
      repeat (3) begin
         step();
         chk("t3_dma_blocked", 64'(bus.slv_aw_ready_o[0]), 64'(0));
      end
      bus.slv_aw_valid_i = 2'b11;
      repeat (4) step();
      chk("t3_total8", 64'(wr_out), 64'(8'h26));
      repeat (3) begin
         step();
         chk("t3_all_blocked", 64'(bus.slv_aw_ready_o), 64'(0));
      end
      b_done = 2'b10;
      step();
      b_done = 2'b00;
      step();
      chk("t3_hdir_resume", 64'(bus.mst_aw_valid_o), 64'(2'b10));
      step();
      bus.slv_aw_valid_i = 2'b00;
      chk("t3_wr_out", 64'(wr_out), 64'(8'h26));
      drain();

      // enable drop during a stalled grant
      bus.slv_aw_valid_i = 2'b01;
      bus.mst_aw_ready_i = 2'b00;
      step();
      enable = 1'b0;
      repeat (5) begin
         step();
         chk("t4_held", 64'(bus.mst_aw_valid_o), 64'(2'b01));
      end
      bus.mst_aw_ready_i = 2'b01;
      step();
      repeat (3) begin
         step();
         chk("t4_no_grant", 64'(bus.mst_aw_valid_o), 64'(0));
      end
      bus.slv_aw_valid_i = 2'b00;
      enable = 1'b1;
      drain();

      // underflow
      b_done = 2'b10;
      step();
      b_done = 2'b00;
      chk("t5_err", 64'(err), 64'(1));
      chk("t5_wr_out", 64'(wr_out), 64'(0));
      step();
      chk("t5_err_sticky", 64'(err), 64'(1));

      // reset in the middle of a host-direct read grant
      bus.slv_ar_valid_i = 2'b10;
      bus.mst_ar_ready_i = 2'b10;
      repeat (6) step();
      chk("t6_rd3", 64'(rd_out), 64'(8'h30));
      bus.mst_ar_ready_i = 2'b00;
      step();
      chk("t6_gnt_hdir", 64'(bus.mst_ar_valid_o), 64'(2'b10));
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_valid", 64'(bus.mst_ar_valid_o), 64'(0));
      chk("t6_rst_ready", 64'(bus.slv_ar_ready_o), 64'(0));
      chk("t6_rst_rd_out", 64'(rd_out), 64'(0));
      chk("t6_rst_err", 64'(err), 64'(0));
      model_reset();
      all_inputs_zero();
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("t6_idle", 64'(idle), 64'(1));

      // randomized traffic
      repeat (3000) begin
         for (int c = 0; c < 2; c++) begin
            for (int p = 0; p < 2; p++) begin
               bit v, r, d;
               v = (m_gnt[c] == p) ? vld(c, p) : ($urandom_range(2, 0) != 0);
               r = ($urandom_range(3, 0) != 0);
               d = (m_cnt[c][p] > 0) && ($urandom_range(3, 0) == 0);
               if (c == 0) begin
                  bus.slv_aw_valid_i[p] = v; bus.mst_aw_ready_i[p] = r; b_done[p] = d;
               end else begin
                  bus.slv_ar_valid_i[p] = v; bus.mst_ar_ready_i[p] = r; r_done[p] = d;
               end
            end
         end
         enable = ($urandom_range(15, 0) != 0);
         step();
      end
      drain();
      step();
      chk("final_idle", 64'(idle), 64'(1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
